addsub_result_collector: RTL

- Downstream companion of the team's pipelined ripple adder-subtractor (WIDTH-bit, fixed latency, no valid/stall).
- Tracks issued operations through the fixed pipeline latency with a valid/tag delay line, captures SUM/carry-borrow into a result FIFO, and presents results on a valid/ready interface.
- Issues credit-based backpressure, because the adder pipeline cannot stall: no issued result is ever lost.

---
 rtl/addsub_pkg.sv | 12 +
 rtl/addsub_result_fifo.sv | 42 ++++
 rtl/addsub_result_collector.sv | 74 +++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the adder-subtractor result path.
package addsub_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_LATENCY = DEF_WIDTH + 2;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef struct packed {
    logic op;
    logic flag;
    logic [DEF_WIDTH-1:0] sum;
  } result_t;
endpackage

// File: rtl/addsub_result_fifo.sv
// addsub_result_fifo: first-word-fall-through result FIFO that drops writes when full without a pop.
module addsub_result_fifo #(
  parameter int W = 6,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, do_pop, do_push;
  assign valid = occupancy != '0;
  assign full = occupancy == OW'(DEPTH);
  assign do_pop = pop & valid;
  // a pop frees the head slot in the same edge, so a full FIFO can still accept
  assign do_push = push & (!full | do_pop);
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      occupancy <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      occupancy <= occupancy + OW'(do_push) - OW'(do_pop);
      if (push & !do_push) overrun <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/addsub_result_collector.sv
// addsub_result_collector: tracks adder issues through the fixed latency and buffers results under credit.
// Optional ADDSUB_STALL_CNT_EN adds a saturating stall_cnt output.
module addsub_result_collector
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LATENCY = WIDTH + 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     issue_addsub,
  input  logic [WIDTH-1:0]         res_sum,
  input  logic                     res_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_flag,
  output logic                     out_op,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_overrun
`ifdef ADDSUB_STALL_CNT_EN
  ,
  output logic [7:0]               stall_cnt
`endif
);
  localparam int IW = $clog2(LATENCY + 1);
  typedef struct packed {
    logic op;
    logic flag;
    logic [WIDTH-1:0] sum;
  } entry_t;
  entry_t head;
  logic [LATENCY-1:0] tag_v, tag_op;
  logic [IW-1:0] inflight;
  logic fire, tail;
  assign fire = issue_valid & issue_ready;
  assign tail = tag_v[LATENCY-1];
  // credit counts results already queued plus those still inside the adder
  assign issue_ready = int'(occupancy) + int'(inflight) < DEPTH;
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_op <= '0;
      inflight <= '0;
    end else begin
      tag_v <= {tag_v[LATENCY-2:0], fire};
      tag_op <= {tag_op[LATENCY-2:0], issue_addsub};
      inflight <= inflight + IW'(fire) - IW'(tail);
    end
  end
  addsub_result_fifo #(.W(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail),
    .din       ({tag_op[LATENCY-1], res_cout, res_sum}),
    .pop       (out_ready),
    .dout      (head),
    .valid     (out_valid),
    .occupancy (occupancy),
    .overrun   (err_overrun)
  );
  assign out_op = head.op;
  assign out_flag = head.flag;
  assign out_sum = head.sum;
`ifdef ADDSUB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (issue_valid & !issue_ready & (stall_cnt != 8'hFF)) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
